uart_cmd_wrapper: RTL
=====================

Name: uart_cmd_wrapper

Overview:
Sits between the Knight's UART transceiver and the command processor. It assembles two received UART bytes (high byte first) into one 16-bit command with a ready/clear handshake, and serializes the processor's 8-bit response (0xA5 positive ack, 0x5A move ack) back out through the UART transmitter. This is the consumer of the 16-bit commands the bench's send task issues over BLE, and the source of the ack byte the bench's ack-check task waits on.

Parameters:
BYTE_TIMEOUT, 1000000, clk cycles allowed between high and low byte before the partial frame is discarded; must be >= 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rx_rdy  input  1  UART rx byte valid; level, held until cleared
rx_data  input  8  UART rx byte
clr_rx_rdy  output  1  combinational; high in the cycle a byte is consumed
cmd  output  16  assembled command; changes only on frame completion
cmd_rdy  output  1  command valid; level
clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy
resp  input  8  response byte to send
send_resp  input  1  single-cycle request to transmit resp
resp_sent  output  1  one-cycle pulse when the response byte has left the transmitter
trmt  output  1  one-cycle pulse to UART tx starting a byte
tx_data  output  8  byte to UART tx; held stable while busy
tx_done  input  1  UART tx byte complete
frame_err  output  1  one-cycle pulse on inter-byte timeout

Behaviour:
- Reset (sync, rst=1 at rising edge): cmd=0, cmd_rdy=0, resp_sent=0, trmt=0, tx_data=0, frame_err=0, RX FSM=RX_HIGH, TX FSM=TX_IDLE, timer=0, high-byte holding reg=0. Reset mid-frame or mid-transmit drops all state. No resp_sent is produced for an aborted byte.
- RX FSM states:
  - RX_HIGH: when rx_rdy=1, clr_rx_rdy=1 in the same cycle. On the next edge, rx_data goes into the holding reg, timer=0, and the FSM moves to RX_LOW.
  - RX_LOW: when rx_rdy=1, clr_rx_rdy=1 in the same cycle. On the next edge, cmd={hold,rx_data}, cmd_rdy=1, and the FSM returns to RX_HIGH.
  - RX_LOW timeout: the timer increments each cycle with rx_rdy=0. When timer==BYTE_TIMEOUT-1 and rx_rdy=0, frame_err=1 for one cycle, the holding reg is discarded, the FSM returns to RX_HIGH, and cmd/cmd_rdy are unchanged.
- A byte arriving in the same cycle as the timeout is accepted; there is no frame_err.
- clr_rx_rdy is never high while rx_rdy=0. The upstream receiver drops rx_rdy on the edge after clr_rx_rdy, so each byte is consumed exactly once.
- cmd is atomic: a pending high byte never disturbs cmd. cmd holds its value from frame completion until the next frame completes.
- cmd_rdy:
  - Cleared on the edge where clr_cmd_rdy=1.
  - Also cleared when a new high byte is captured, because the old command is being superseded.
  - If frame completion and clr_cmd_rdy occur in the same cycle, set wins: cmd_rdy=1 with the new cmd.
- TX FSM states:
  - TX_IDLE: send_resp=1 → tx_data<=resp, trmt=1 for exactly the next cycle, then TX_BUSY.
  - TX_BUSY: tx_done=1 → resp_sent=1 for one cycle, then TX_IDLE. send_resp while in TX_BUSY is ignored (no queuing) and tx_data does not change.
- A send_resp that arrives in the same cycle as resp_sent is accepted, because the FSM is already in TX_IDLE that cycle.
- The RX and TX paths are fully independent and may operate concurrently.

Test Plan:
- Reset then two bytes 0x2C, 0x01 with a 100-cycle gap (BYTE_TIMEOUT=1000) → exactly two clr_rx_rdy pulses, cmd=0x2C01, cmd_rdy=1. Then clr_cmd_rdy → cmd_rdy=0 next edge, cmd still 0x2C01.
- BYTE_TIMEOUT=50: high byte 0x40, no further byte → frame_err pulse 50 cycles after capture, cmd unchanged. Then bytes 0x12, 0x34 → cmd=0x1234.
- A low byte arriving exactly on the timeout cycle → no frame_err, command assembled.
- cmd_rdy=1 with cmd=0x1234, new high byte 0x56 → cmd_rdy drops, cmd remains 0x1234 until low byte 0x78 → cmd=0x5678. Same-cycle clr_cmd_rdy with low byte → cmd_rdy=1.
- send_resp with resp=0xA5 → trmt one-cycle pulse, tx_data=0xA5. send_resp with 0x5A while busy → ignored, tx_data stays 0xA5. tx_done → resp_sent pulse. Then resp=0x5A → transmitted.
- rst asserted in RX_LOW and in TX_BUSY → all outputs 0. A subsequent tx_done yields no resp_sent. A following full frame 0xBEEF assembles correctly.

Source files
------------

// File: rtl/uart_cmd_wrapper.sv
// Bridges the UART transceiver and the command processor: pairs received
// bytes (high first) into 16-bit commands and sends one-byte responses back.
module uart_cmd_wrapper #(
  parameter int unsigned BYTE_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(BYTE_TIMEOUT);

  typedef enum logic {RX_HIGH = 1'b0, RX_LOW = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_BUSY = 1'b1} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [7:0]    hold, hold_d;
  logic [TW-1:0] timer, timer_d;
  logic [15:0]   cmd_d;
  logic          cmd_rdy_d;
  logic          frame_err_d;
  logic          trmt_d;
  logic          resp_sent_d;
  logic [7:0]    tx_data_d;
  logic          timeout;

  // Inter-byte timeout fires only while waiting for a low byte that has not arrived.
  assign timeout = (rx_state == RX_LOW) && !rx_rdy && (timer == TW'(BYTE_TIMEOUT - 1));

  // State and output registers for both paths.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= RX_HIGH;
      tx_state  <= TX_IDLE;
      hold      <= '0;
      timer     <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
      frame_err <= 1'b0;
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      tx_data   <= '0;
    end else begin
      rx_state  <= rx_next;
      tx_state  <= tx_next;
      hold      <= hold_d;
      timer     <= timer_d;
      cmd       <= cmd_d;
      cmd_rdy   <= cmd_rdy_d;
      frame_err <= frame_err_d;
      trmt      <= trmt_d;
      resp_sent <= resp_sent_d;
      tx_data   <= tx_data_d;
    end
  end

  // RX next-state: every valid byte advances; a timeout abandons the frame.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_HIGH: if (rx_rdy) rx_next = RX_LOW;
      RX_LOW:  if (rx_rdy || timeout) rx_next = RX_HIGH;
      default: rx_next = RX_HIGH;
    endcase
  end

  // RX outputs: byte consume strobe, holding reg, timer and command assembly.
  always_comb begin
    clr_rx_rdy  = 1'b0;
    hold_d      = hold;
    timer_d     = timer;
    cmd_d       = cmd;
    cmd_rdy_d   = cmd_rdy & ~clr_cmd_rdy;
    frame_err_d = 1'b0;
    case (rx_state)
      RX_HIGH: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          hold_d     = rx_data;
          timer_d    = '0;
          cmd_rdy_d  = 1'b0;
        end
      end
      RX_LOW: begin
        if (rx_rdy) begin
          clr_rx_rdy = 1'b1;
          cmd_d      = {hold, rx_data};
          cmd_rdy_d  = 1'b1;
          hold_d     = '0;
          timer_d    = '0;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          hold_d      = '0;
          timer_d     = '0;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // TX next-state: one byte in flight at a time, no request queuing.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (send_resp) tx_next = TX_BUSY;
      TX_BUSY: if (tx_done) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: start pulse with latched byte, completion pulse on tx_done.
  always_comb begin
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    tx_data_d   = tx_data;
    case (tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          trmt_d    = 1'b1;
          tx_data_d = resp;
        end
      end
      TX_BUSY: if (tx_done) resp_sent_d = 1'b1;
      default: ;
    endcase
  end

endmodule
